// File: rtl/trunc_pkg.sv
// Shared widths, saturation limits and word types for the truncation stage.
package trunc_pkg;

   localparam int unsigned TRUNC_W = 24;
   localparam int unsigned TRUNC_F = 10;

   typedef logic [2*TRUNC_W-1:0] prod_t;
   typedef logic [TRUNC_W-1:0]   word_t;

   localparam word_t SAT_MAX = {1'b0, {(TRUNC_W-1){1'b1}}};
   localparam word_t SAT_MIN = {1'b1, {(TRUNC_W-1){1'b0}}};

endpackage

// File: rtl/trunc_sat_comb.sv
// Combinational floor slice, overflow detect and saturation mux for a 2W-bit product.
module trunc_sat_comb
   import trunc_pkg::*;
#(
   parameter int unsigned W = TRUNC_W,
   parameter int unsigned F = TRUNC_F
) (
   input  logic [2*W-1:0] i_sum,
   output logic [W-1:0]   o_word_c,
   output logic           o_ovf_c
);

   localparam int unsigned SIGN_W = W - F + 1;
   localparam logic [W-1:0] LP_SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] LP_SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0]      w_candidate;
   logic [SIGN_W-1:0] w_sign_field;
   logic              w_ext_ok;

   // Dropping the low F bits of a two's-complement value is a floor toward -inf.
   assign w_candidate  = i_sum[F+W-1:F];
   assign w_sign_field = i_sum[2*W-1:F+W-1];
   assign w_ext_ok     = (&w_sign_field) | ~(|w_sign_field);

   always_comb begin
      o_word_c = w_candidate;
      o_ovf_c  = 1'b0;
      if (!w_ext_ok) begin
         o_ovf_c  = 1'b1;
         o_word_c = i_sum[2*W-1] ? LP_SAT_MIN : LP_SAT_MAX;
      end
   end

endmodule

// File: rtl/truncamiento_sat.sv
// Registered truncation/saturation stage: 2W-bit signed product in, W-bit word out, 1-cycle latency.
module truncamiento_sat
   import trunc_pkg::*;
#(
   parameter int unsigned W = TRUNC_W,
   parameter int unsigned F = TRUNC_F
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [2*W-1:0] Datos_Sum,
   input  logic           Valid_In,
   output logic [W-1:0]   Datos_Trunc,
   output logic           Valid_Out,
   output logic           Ovf
);

   logic [W-1:0] w_word;
   logic         w_ovf;
   logic [W-1:0] r_data;
   logic         r_ovf;
   logic         r_valid;

   trunc_sat_comb #(
      .W (W),
      .F (F)
   ) u_trunc_sat_comb (
      .i_sum    (Datos_Sum),
      .o_word_c (w_word),
      .o_ovf_c  (w_ovf)
   );

   // Data and flag only update on valid samples; otherwise they hold.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_data  <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= Valid_In;
         if (Valid_In) begin
            r_data <= w_word;
            r_ovf  <= w_ovf;
         end
      end
   end

   assign Datos_Trunc = r_data;
   assign Valid_Out   = r_valid;
   assign Ovf         = r_ovf;

endmodule

// File: tb/tb_truncamiento_sat.sv
// Self-checking bench for truncamiento_sat: directed cases plus randomized stream vs. arithmetic model.
module tb_truncamiento_sat;
   import trunc_pkg::*;

   logic  CLK;
   logic  RST;
   prod_t Datos_Sum;
   logic  Valid_In;
   word_t Datos_Trunc;
   logic  Valid_Out;
   logic  Ovf;

   int total;
   int bad;

   truncamiento_sat dut (
      .CLK         (CLK),
      .RST         (RST),
      .Datos_Sum   (Datos_Sum),
      .Valid_In    (Valid_In),
      .Datos_Trunc (Datos_Trunc),
      .Valid_Out   (Valid_Out),
      .Ovf         (Ovf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: floor-divide the signed product by 2^F, then clamp to the W-bit signed range.
   function automatic void ref_model(input prod_t x, output word_t w, output logic o);
      longint signed v;
      longint signed q;
      longint signed div;
      longint signed hi;
      longint signed lo;
      v   = longint'($signed(x));
      div = longint'(1) << TRUNC_F;
      hi  = (longint'(1) << (TRUNC_W - 1)) - 1;
      lo  = -(longint'(1) << (TRUNC_W - 1));
      q   = v / div;
      if (v < 0 && (v % div) != 0) q = q - 1;
      if (q > hi) begin
         w = SAT_MAX;
         o = 1'b1;
      end else if (q < lo) begin
         w = SAT_MIN;
         o = 1'b1;
      end else begin
         w = TRUNC_W'(q);
         o = 1'b0;
      end
   endfunction

   // Present one input on the falling edge, then let the rising edge capture it.
   task automatic drive(input prod_t s, input logic v);
      @(negedge CLK);
      Datos_Sum = s;
      Valid_In  = v;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      drive(48'h000000100000, 1'b1);
      @(negedge CLK);
      Valid_In = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      total++;
      if (Datos_Trunc !== 24'h0 || Valid_Out !== 1'b0 || Ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: got data=%h valid=%b ovf=%b want 000000/0/0", Datos_Trunc, Valid_Out, Ovf);
      end
      repeat (2) @(posedge CLK);
      #1;
      total++;
      if (Datos_Trunc !== 24'h0 || Valid_Out !== 1'b0 || Ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold: got data=%h valid=%b ovf=%b want 000000/0/0", Datos_Trunc, Valid_Out, Ovf);
      end
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_directed();
      prod_t vec [7];
      word_t exp_w [7];
      logic  exp_o [7];
      vec[0] = 48'h000000100000; exp_w[0] = 24'h000400; exp_o[0] = 1'b0;
      vec[1] = 48'hFFFFFFF00000; exp_w[1] = 24'hFFFC00; exp_o[1] = 1'b0;
      vec[2] = 48'h0000001003FF; exp_w[2] = 24'h000400; exp_o[2] = 1'b0;
      vec[3] = 48'hFFFFFFEFFFFF; exp_w[3] = 24'hFFFBFF; exp_o[3] = 1'b0;
      vec[4] = 48'h000200000000; exp_w[4] = 24'h7FFFFF; exp_o[4] = 1'b1;
      vec[5] = 48'h800000000000; exp_w[5] = 24'h800000; exp_o[5] = 1'b1;
      vec[6] = 48'h0001FFFFFFFF; exp_w[6] = 24'h7FFFFF; exp_o[6] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive(vec[i], 1'b1);
         total++;
         if (Datos_Trunc !== exp_w[i] || Ovf !== exp_o[i] || Valid_Out !== 1'b1) begin
            bad++;
            $display("FAIL directed[%0d] in=%h: got data=%h ovf=%b valid=%b want %h/%b/1",
                     i, vec[i], Datos_Trunc, Ovf, Valid_Out, exp_w[i], exp_o[i]);
         end
      end
      // Most negative representable value, sign-extended, must not saturate.
      drive(48'hFFFE00000000, 1'b1);
      total++;
      if (Datos_Trunc !== 24'h800000 || Ovf !== 1'b0) begin
         bad++;
         $display("FAIL min_boundary: got data=%h ovf=%b want 800000/0", Datos_Trunc, Ovf);
      end
   endtask

   task automatic test_back_to_back();
      prod_t s;
      word_t ew;
      logic  eo;
      int    errs;
      errs = 0;
      for (int i = 0; i < 5000; i++) begin
         case ($urandom_range(0, 2))
            0: s = {$urandom(), $urandom()};
            1: s = prod_t'($signed({$urandom_range(0, 3), $urandom()}) <<< 0) | {{14{s[0]}}, 34'h0};
            default: begin
               s = {$urandom(), $urandom()};
               s[47:33] = {15{s[32]}};
            end
         endcase
         ref_model(s, ew, eo);
         drive(s, 1'b1);
         total++;
         if (Datos_Trunc !== ew || Ovf !== eo || Valid_Out !== 1'b1) begin
            bad++;
            errs++;
            if (errs <= 10)
               $display("FAIL stream[%0d] in=%h: got data=%h ovf=%b valid=%b want %h/%b/1",
                        i, s, Datos_Trunc, Ovf, Valid_Out, ew, eo);
         end
      end
   endtask

   task automatic test_valid_gating();
      prod_t s;
      word_t ew;
      logic  eo;
      s = 48'h7FF000000000;
      ref_model(s, ew, eo);
      drive(s, 1'b1);
      total++;
      if (Datos_Trunc !== ew || Ovf !== eo || Valid_Out !== 1'b1) begin
         bad++;
         $display("FAIL gate_load: got data=%h ovf=%b valid=%b want %h/%b/1", Datos_Trunc, Ovf, Valid_Out, ew, eo);
      end
      for (int i = 0; i < 3; i++) begin
         drive({$urandom(), $urandom()} & 48'h0000FFFFFFFF, 1'b0);
         total++;
         if (Valid_Out !== 1'b0 || Datos_Trunc !== ew || Ovf !== eo) begin
            bad++;
            $display("FAIL gate_hold[%0d]: got data=%h ovf=%b valid=%b want %h/%b/0", i, Datos_Trunc, Ovf, Valid_Out, ew, eo);
         end
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge CLK);
      Datos_Sum = 48'h000000100000;
      Valid_In  = 1'b1;
      #2;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      total++;
      if (Valid_Out !== 1'b0 || Datos_Trunc !== 24'h0 || Ovf !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_lost: got data=%h ovf=%b valid=%b want 000000/0/0", Datos_Trunc, Ovf, Valid_Out);
      end
      @(negedge CLK);
      RST = 1'b0;
      Valid_In = 1'b0;
      @(posedge CLK);
      #1;
      total++;
      if (Valid_Out !== 1'b0 || Datos_Trunc !== 24'h0) begin
         bad++;
         $display("FAIL rst_mid_idle: got data=%h valid=%b want 000000/0", Datos_Trunc, Valid_Out);
      end
      drive(48'hFFFFFFF00000, 1'b1);
      total++;
      if (Valid_Out !== 1'b1 || Datos_Trunc !== 24'hFFFC00 || Ovf !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_first: got data=%h ovf=%b valid=%b want fffc00/0/1", Datos_Trunc, Ovf, Valid_Out);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      RST       = 1'b1;
      Datos_Sum = '0;
      Valid_In  = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_valid_gating();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
